// File: rtl/match_timer_if.sv
// Load channel for match_timer: period/compare values offered with a valid/ready handshake.
interface match_timer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_period;
    logic [WIDTH-1:0] load_cmp;

    modport master (
        output load_valid,
        output load_period,
        output load_cmp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_period,
        input  load_cmp,
        output load_ready
    );
endinterface

// File: rtl/match_timer.sv
// Programmable up-counter with registered match/wrap pulses, sticky irq and double-buffered reload.
// Optional PWM output enabled by defining MATCH_TIMER_PWM_EN.
module match_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             en,
    input  logic             one_shot,
    match_timer_if.slave     load,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             wrap,
    output logic             busy,
    output logic             irq,
    output logic             pwm_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, cmp_q;
    logic [WIDTH-1:0] period_sh, cmp_sh;
    logic             pending_q;
    logic             mode_q;
    logic             match_q, wrap_q, irq_q;
    logic             step, hit, do_wrap, accept;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        step    = (state_q == RUN) && en;
        hit     = step && (count_q == cmp_q);
        do_wrap = step && (count_q == period_q);
        accept  = load.load_valid && !pending_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (en && (period_q != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    if (count_q == period_q) begin
                        count_d = '0;
                        if (mode_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
            DONE: begin
                count_d = '0;
                if (!en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            cmp_q     <= '0;
            period_sh <= '0;
            cmp_sh    <= '0;
            pending_q <= 1'b0;
            mode_q    <= 1'b0;
            match_q   <= 1'b0;
            wrap_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            match_q <= hit;
            wrap_q  <= do_wrap;
            irq_q   <= hit | (irq_q & ~irq_clr);
            if ((state_q == IDLE) && (state_d == RUN)) begin
                mode_q <= one_shot;
            end
            // accept implies !pending_q, so a wrap-cycle load lands in the shadow for the next wrap
            if (do_wrap && pending_q) begin
                period_q  <= period_sh;
                cmp_q     <= cmp_sh;
                pending_q <= 1'b0;
            end
            if (accept) begin
                if (state_q == RUN) begin
                    period_sh <= load.load_period;
                    cmp_sh    <= load.load_cmp;
                    pending_q <= 1'b1;
                end else begin
                    period_q <= load.load_period;
                    cmp_q    <= load.load_cmp;
                end
            end
        end
    end

`ifdef MATCH_TIMER_PWM_EN
    logic pwm_q;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (state_q == RUN) && (count_q < cmp_q);
        end
    end

    assign pwm_out = pwm_q;
`else
    assign pwm_out = 1'b0;
`endif

    assign load.load_ready = !pending_q;
    assign count           = count_q;
    assign match           = match_q;
    assign wrap            = wrap_q;
    assign busy            = (state_q != IDLE);
    assign irq             = irq_q;

endmodule

// File: tb/tb_match_timer.sv
// Scoreboard bench for match_timer: expected per-cycle outputs are queued with the stimulus and popped each clock.
module tb_match_timer;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         nReset;
    logic         en;
    logic         one_shot;
    logic         irq_clr;
    logic [W-1:0] count;
    logic         match;
    logic         wrap;
    logic         busy;
    logic         irq;
    logic         pwm_out;

    match_timer_if #(.WIDTH(W)) lif ();

    match_timer #(.WIDTH(W)) dut (
        .clk     (clk),
        .nReset  (nReset),
        .en      (en),
        .one_shot(one_shot),
        .load    (lif),
        .irq_clr (irq_clr),
        .count   (count),
        .match   (match),
        .wrap    (wrap),
        .busy    (busy),
        .irq     (irq),
        .pwm_out (pwm_out)
    );

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         m;
        logic         w;
        logic         b;
        logic         i;
        logic         r;
    } obs_t;

    obs_t sb[$];
    logic pwm_sb[$];
    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t mk(int c, bit m, bit w, bit b, bit i, bit r);
        obs_t o;
        o.cnt = W'(c);
        o.m   = m;
        o.w   = w;
        o.b   = b;
        o.i   = i;
        o.r   = r;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(int'(count), match, wrap, busy, irq, lif.load_ready);
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("cnt=%0d match=%b wrap=%b busy=%b irq=%b ready=%b", o.cnt, o.m, o.w, o.b, o.i, o.r);
    endfunction

    task automatic do_reset(int unsigned n);
        nReset          = 1'b0;
        en              = 1'b0;
        one_shot        = 1'b0;
        irq_clr         = 1'b0;
        lif.load_valid  = 1'b0;
        lif.load_period = '0;
        lif.load_cmp    = '0;
        repeat (n) step();
        nReset = 1'b1;
    endtask

    task automatic do_load(int p, int c);
        lif.load_valid  = 1'b1;
        lif.load_period = W'(p);
        lif.load_cmp    = W'(c);
        step();
        lif.load_valid  = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        nReset          = 1'b0;
        en              = 1'b1;
        one_shot        = 1'b0;
        irq_clr         = 1'b0;
        lif.load_valid  = 1'b0;
        lif.load_period = '0;
        lif.load_cmp    = '0;
        repeat (5) step();
        sb.push_back(mk(0, 0, 0, 0, 0, 1));
        sb.push_back(mk(0, 0, 0, 0, 0, 1));
        exp = sb.pop_front();
        got = sample();
        total++;
        if (got !== exp) $display("FAIL reset_held got %s want %s", fmt(got), fmt(exp));
        else passed++;
        nReset = 1'b1;
        step();
        exp = sb.pop_front();
        got = sample();
        total++;
        if (got !== exp) $display("FAIL reset_released got %s want %s", fmt(got), fmt(exp));
        else passed++;
        total++;
        if (pwm_out !== 1'b0) $display("FAIL reset_pwm got %b want 0", pwm_out);
        else passed++;
    endtask

    task automatic test_periodic();
        obs_t got, exp;
        do_reset(2);
        do_load(9, 4);
        en = 1'b1;
        for (int j = 0; j < 25; j++)
            sb.push_back(mk(j % 10, (j >= 1) && ((j - 1) % 10 == 4), (j >= 1) && ((j - 1) % 10 == 9), 1, j >= 5, 1));
        for (int j = 0; j < 25; j++) begin
            step();
            exp = sb.pop_front();
            got = sample();
            total++;
            if (got !== exp) $display("FAIL periodic[%0d] got %s want %s", j, fmt(got), fmt(exp));
            else passed++;
        end
        // irq_clr coincides with a match edge first (set wins), then clears
        irq_clr = 1'b1;
        sb.push_back(mk(5, 1, 0, 1, 1, 1));
        sb.push_back(mk(6, 0, 0, 1, 0, 1));
        for (int j = 0; j < 2; j++) begin
            step();
            exp = sb.pop_front();
            got = sample();
            total++;
            if (got !== exp) $display("FAIL irq_clr[%0d] got %s want %s", j, fmt(got), fmt(exp));
            else passed++;
        end
        irq_clr = 1'b0;
    endtask

    task automatic test_reload();
        obs_t got, exp;
        int m;
        for (int k = 0; k < 13; k++) begin
            if (k < 3) begin
                sb.push_back(mk(7 + k, 0, 0, 1, 0, 0));
            end else begin
                m = k - 3;
                sb.push_back(mk(m % 4, (m >= 1) && ((m - 1) % 4 == 1),
                                (m == 0) || ((m >= 1) && ((m - 1) % 4 == 3)), 1, m >= 2, 1));
            end
        end
        lif.load_valid  = 1'b1;
        lif.load_period = W'(3);
        lif.load_cmp    = W'(1);
        for (int k = 0; k < 13; k++) begin
            step();
            if (k == 0) begin
                lif.load_period = W'(7);
                lif.load_cmp    = W'(0);
            end
            if (k == 2) lif.load_valid = 1'b0;
            exp = sb.pop_front();
            got = sample();
            total++;
            if (got !== exp) $display("FAIL reload[%0d] got %s want %s", k, fmt(got), fmt(exp));
            else passed++;
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) sb.push_back(mk(1, 0, 0, 1, 1, 1));
        for (int k = 0; k < 3; k++) begin
            step();
            exp = sb.pop_front();
            got = sample();
            total++;
            if (got !== exp) $display("FAIL pause[%0d] got %s want %s", k, fmt(got), fmt(exp));
            else passed++;
        end
    endtask

    task automatic test_one_shot();
        obs_t got, exp;
        do_reset(2);
        do_load(5, 2);
        one_shot = 1'b1;
        en       = 1'b1;
        for (int j = 0; j < 10; j++)
            sb.push_back(mk((j <= 5) ? j : 0, j == 3, j == 6, 1, j >= 3, 1));
        for (int j = 0; j < 10; j++) begin
            step();
            exp = sb.pop_front();
            got = sample();
            total++;
            if (got !== exp) $display("FAIL one_shot[%0d] got %s want %s", j, fmt(got), fmt(exp));
            else passed++;
        end
        en       = 1'b0;
        one_shot = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 1, 1));
        step();
        exp = sb.pop_front();
        got = sample();
        total++;
        if (got !== exp) $display("FAIL done_to_idle got %s want %s", fmt(got), fmt(exp));
        else passed++;
    endtask

    task automatic test_no_match();
        obs_t got, exp;
        do_reset(2);
        do_load(9, 20);
        en = 1'b1;
        for (int j = 0; j < 30; j++)
            sb.push_back(mk(j % 10, 0, (j >= 1) && ((j - 1) % 10 == 9), 1, 0, 1));
        for (int j = 0; j < 30; j++) begin
            step();
            exp = sb.pop_front();
            got = sample();
            total++;
            if (got !== exp) $display("FAIL cmp_above_period[%0d] got %s want %s", j, fmt(got), fmt(exp));
            else passed++;
        end
        do_reset(2);
        en = 1'b1;
        for (int j = 0; j < 5; j++) sb.push_back(mk(0, 0, 0, 0, 0, 1));
        for (int j = 0; j < 5; j++) begin
            step();
            exp = sb.pop_front();
            got = sample();
            total++;
            if (got !== exp) $display("FAIL period_zero[%0d] got %s want %s", j, fmt(got), fmt(exp));
            else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_pwm();
        logic exp_pwm;
        int unsigned highs = 0;
        int unsigned want_highs;
        do_reset(2);
        do_load(9, 3);
        en = 1'b1;
        for (int j = 0; j < 31; j++) begin
`ifdef MATCH_TIMER_PWM_EN
            pwm_sb.push_back((j >= 1) && ((j - 1) % 10 < 3));
`else
            pwm_sb.push_back(1'b0);
`endif
        end
`ifdef MATCH_TIMER_PWM_EN
        want_highs = 9;
`else
        want_highs = 0;
`endif
        for (int j = 0; j < 31; j++) begin
            step();
            exp_pwm = pwm_sb.pop_front();
            if (pwm_out === 1'b1) highs++;
            total++;
            if (pwm_out !== exp_pwm) $display("FAIL pwm[%0d] got %b want %b", j, pwm_out, exp_pwm);
            else passed++;
        end
        total++;
        if (highs != want_highs) $display("FAIL pwm_duty got %0d want %0d", highs, want_highs);
        else passed++;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_reload();
        test_one_shot();
        test_no_match();
        test_pwm();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
